aes_key_sched_ctrl: RTL and testbench

Sequential AES-128 key-schedule controller. It accepts a 128-bit cipher key over a valid/ready handshake and expands it iteratively, one round key per clock, into an 11-entry round-key store. It then serves indexed round-key reads to the AES round engine. It replaces the fully combinational 11-key expansion with a single reusable round-expansion stage, trading 10 cycles of latency for area.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_key_round.sv | 28 ++
 rtl/aes_key_sched_ctrl.sv | 131 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative key-schedule controller:
// round count, state encoding, round-key type, S-box and round constants.
package aes_pkg;

    localparam int unsigned NR = 10;

    typedef logic [127:0] round_key_t;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StReady
    } ks_state_e;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon_lut(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion round: derives the next round key from the
// previous one and the round constant. Purely combinational, four S-boxes.
module aes_key_round
    import aes_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;

    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign t   = sub ^ {rcon, 24'h0};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: one round key per cycle into an
// NR+1 entry store, then indexed reads. Define AES_KS_ABORT_EN to allow rekey mid-expansion.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         keys_valid,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    output logic         rk_ack,
    output logic         rk_err
);

    ks_state_e  state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    round_key_t rk_q [NR+1];

    logic       wr_en;
    logic [3:0] wr_idx;
    round_key_t wr_data, prev_key, next_key, rd_key;
    logic [7:0] rcon;
    logic       hs, rd_ok;

    round_key_t rk_data_q;
    logic       rk_ack_q, rk_err_q;

`ifdef AES_KS_ABORT_EN
    assign key_ready = ~rst;
`else
    assign key_ready = ~rst & (state_q != StExpand);
`endif

    assign hs         = key_valid & key_ready;
    assign busy       = (state_q == StExpand);
    assign keys_valid = (state_q == StReady);
    assign rcon       = rcon_lut(rnd_q);

    always_comb begin
        prev_key = '0;
        rd_key   = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (rnd_q - 4'd1 == 4'(i)) prev_key = rk_q[i];
            if (rk_idx == 4'(i))       rd_key   = rk_q[i];
        end
    end

    aes_key_round u_key_round (
        .prev_key (prev_key),
        .rcon     (rcon),
        .next_key (next_key)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = next_key;
        case (state_q)
            StIdle, StReady: begin
                if (hs) begin
                    state_d = StExpand;
                    rnd_d   = 4'd1;
                    wr_en   = 1'b1;
                    wr_data = key_in;
                end
            end
            StExpand: begin
                wr_en  = 1'b1;
                wr_idx = rnd_q;
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == 4'(NR)) begin
                    state_d = StReady;
                    rnd_d   = '0;
                end
`ifdef AES_KS_ABORT_EN
                // A new key restarts expansion from round 1.
                if (hs) begin
                    state_d = StExpand;
                    rnd_d   = 4'd1;
                    wr_idx  = '0;
                    wr_data = key_in;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rnd_q   <= '0;
            for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            for (int unsigned i = 0; i <= NR; i++) begin
                if (wr_en && wr_idx == 4'(i)) rk_q[i] <= wr_data;
            end
        end
    end

    // Reads see the pre-edge store, so a read alongside a rekey returns the old key.
    assign rd_ok = (state_q == StReady) && (32'(rk_idx) <= NR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_data_q <= '0;
            rk_ack_q  <= 1'b0;
            rk_err_q  <= 1'b0;
        end else begin
            rk_ack_q <= rk_req & rd_ok;
            rk_err_q <= rk_req & ~rd_ok;
            if (rk_req && rd_ok) rk_data_q <= rd_key;
        end
    end

    assign rk_data = rk_data_q;
    assign rk_ack  = rk_ack_q;
    assign rk_err  = rk_err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Randomised scoreboard bench for aes_key_sched_ctrl; reference model derives the
// S-box from GF(2^8) arithmetic and expands keys in the word-oriented FIPS-197 form.
module tb_aes_key_sched_ctrl;

    localparam int NR = 10;
`ifdef AES_KS_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         rk_req = 1'b0;
    logic [3:0]   rk_idx = '0;
    logic         key_ready, busy, keys_valid, rk_ack, rk_err;
    logic [127:0] rk_data;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data),
        .rk_ack     (rk_ack),
        .rk_err     (rk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_ack;
        logic [127:0] data;
    } resp_t;

    resp_t        exp_q[$];
    resp_t        mon_r;
    logic [7:0]   sb [256];
    logic [127:0] cur_keys [11];
    logic [127:0] new_keys [11];
    logic [127:0] last_data = '0;
    int           cyc = 0;
    int           acc_t = 0;
    bit           have = 1'b0;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = '0;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic void build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = '0;
            logic [7:0] r, s;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            r = inv;
            s = inv ^ 8'h63;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sb[a] = s;
        end
    endfunction

    function automatic void expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sb[temp[31:24]], sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]]}
                       ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= NR; r++) new_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Reference behaviour at one sampling edge: reads see the pre-edge state.
    task automatic model_edge();
        bit busy_pre = have && (cyc - acc_t <= NR);
        if (rk_req) begin
            if (have && (cyc - acc_t > NR) && rk_idx <= 4'(NR)) begin
                last_data = cur_keys[rk_idx];
                exp_q.push_back('{is_ack: 1'b1, data: last_data});
            end else begin
                exp_q.push_back('{is_ack: 1'b0, data: last_data});
            end
        end
        if (key_valid && (ABORT || !busy_pre)) begin
            expand(key_in);
            cur_keys = new_keys;
            acc_t    = cyc;
            have     = 1'b1;
        end
    endtask

    task automatic check_status();
        bit exp_busy = !rst && have && (cyc - acc_t < NR);
        bit exp_kv   = !rst && have && (cyc - acc_t >= NR);
        bit exp_kr   = !rst && (ABORT || !exp_busy);
        chk("busy", 128'(busy), 128'(exp_busy));
        chk("keys_valid", 128'(keys_valid), 128'(exp_kv));
        chk("key_ready", 128'(key_ready), 128'(exp_kr));
        if (rst) begin
            chk("rst_rk_ack", 128'(rk_ack), 128'd0);
            chk("rst_rk_err", 128'(rk_err), 128'd0);
            chk("rst_rk_data", rk_data, 128'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst) model_edge();
        @(negedge clk);
        check_status();
    endtask

    task automatic idle(input int n);
        key_valid = 1'b0;
        rk_req    = 1'b0;
        repeat (n) step();
    endtask

    task automatic read(input int idx);
        rk_req = 1'b1;
        rk_idx = 4'(idx);
        step();
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Response monitor: every request must be answered exactly one cycle later.
    always @(negedge clk) begin
        if (!rst) begin
            if (rk_ack || rk_err) begin
                checks++;
                if (rk_ack && rk_err) begin
                    errors++;
                    $display("FAIL ack_err_both: ack=%b err=%b required exclusive", rk_ack, rk_err);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: ack=%b err=%b data=%h none required",
                             rk_ack, rk_err, rk_data);
                end else begin
                    mon_r = exp_q.pop_front();
                    if (mon_r.is_ack !== rk_ack || mon_r.data !== rk_data) begin
                        errors++;
                        $display("FAIL read_resp: ack=%b data=%h required ack=%b data=%h",
                                 rk_ack, rk_data, mon_r.is_ack, mon_r.data);
                    end
                end
            end else if (exp_q.size() > 0) begin
                checks++;
                errors++;
                mon_r = exp_q.pop_front();
                $display("FAIL missing_resp: no ack/err, required ack=%b data=%h",
                         mon_r.is_ack, mon_r.data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        repeat (2) @(negedge clk);
        check_status();
        rst = 1'b0;
        idle(1);

        // FIPS-197 key, reads rejected throughout expansion.
        key_in    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key_valid = 1'b1;
        step();
        chk("model_rk1", new_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_rk10", new_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        key_valid = 1'b0;
        for (int i = 0; i < NR; i++) read($urandom_range(0, 15));
        for (int i = 0; i <= NR; i++) read(i);
        read(11);
        read(15);
        idle(2);

        // Rekey with a simultaneous read of the last round key.
        key_in    = 128'h000102030405060708090a0b0c0d0e0f;
        key_valid = 1'b1;
        read(10);
        key_valid = 1'b0;
        chk("model_rk10_b", new_keys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        idle(10);
        read(10);
        read(0);
        idle(1);

        // key_valid during expansion: ignored, or a restart when aborts are enabled.
        key_in    = rand_key();
        key_valid = 1'b1;
        step();
        idle(3);
        key_in    = rand_key();
        key_valid = 1'b1;
        read(3);
        idle(NR + 2);
        for (int i = 0; i <= NR; i++) read(i);

        // key_valid held high in READY rekeys on every handshake.
        for (int i = 0; i < 30; i++) begin
            key_valid = 1'b1;
            key_in    = rand_key();
            rk_req    = 1'($urandom_range(0, 1));
            rk_idx    = 4'($urandom_range(0, 15));
            step();
        end
        idle(NR + 1);

        for (int i = 0; i < 400; i++) begin
            key_valid = ($urandom_range(0, 15) == 0);
            key_in    = rand_key();
            rk_req    = 1'($urandom_range(0, 1));
            rk_idx    = 4'($urandom_range(0, 15));
            step();
        end
        idle(NR + 2);

        // Reset while expansion sits at round 5.
        key_in    = rand_key();
        key_valid = 1'b1;
        step();
        idle(4);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_keys_valid", 128'(keys_valid), 128'd0);
        chk("midrst_key_ready", 128'(key_ready), 128'd0);
        chk("midrst_rk_ack", 128'(rk_ack), 128'd0);
        chk("midrst_rk_err", 128'(rk_err), 128'd0);
        chk("midrst_rk_data", rk_data, 128'd0);
        have      = 1'b0;
        last_data = '0;
        exp_q.delete();
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        read(2);
        key_in    = rand_key();
        key_valid = 1'b1;
        step();
        idle(NR);
        for (int i = 0; i <= NR; i++) read(i);
        read(11);
        idle(3);

        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
